// File: rtl/apb_req_arbiter_if.sv
// Bundle of requester, response and APB-master command signals shared by the
// round-robin arbiter (master modport) and its surroundings (slave modport).
interface apb_req_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_grant;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]         resp_rdata;
  logic                      resp_err;
  logic                      busy;
  logic                      mst_transfer;
  logic                      mst_read_write;
  logic [ADDR_W-1:0]         mst_write_paddr;
  logic [ADDR_W-1:0]         mst_read_paddr;
  logic [DATA_W-1:0]         mst_write_data;
  logic                      PENABLE;
  logic                      PREADY;
  logic                      PSLVERR;
  logic [DATA_W-1:0]         PRDATA;

  // Arbiter side: consumes requests and APB status, drives grants and commands.
  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  PENABLE, PREADY, PSLVERR, PRDATA,
    output req_grant, resp_valid, resp_rdata, resp_err, busy,
    output mst_transfer, mst_read_write, mst_write_paddr, mst_read_paddr, mst_write_data
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output PENABLE, PREADY, PSLVERR, PRDATA,
    input  req_grant, resp_valid, resp_rdata, resp_err, busy,
    input  mst_transfer, mst_read_write, mst_write_paddr, mst_read_paddr, mst_write_data
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master among NUM_REQ requesters, with a
// PREADY stall watchdog and a one-cycle response pulse back to the owner.
module apb_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input logic PCLK,
  input logic PRESET,
  apb_req_arbiter_if.master bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]         state_r;
  logic [IDX_W-1:0]   rr_ptr_r;
  logic [IDX_W-1:0]   owner_r;
  logic [NUM_REQ-1:0] grant_r;
  logic [NUM_REQ-1:0] resp_valid_r;
  logic               rw_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [DATA_W-1:0]  wdata_r;
  logic [DATA_W-1:0]  rdata_r;
  logic               err_r;
  logic [7:0]         tmo_cnt_r;

  logic [IDX_W-1:0]   pick_s;
  logic               found_s;
  int                 cand_s;
  logic               timeout_s;
  logic               term_s;

  // Round-robin search starting one past the last owner, wrapping at NUM_REQ.
  always_comb begin
    found_s = 1'b0;
    pick_s  = {IDX_W{1'b0}};
    cand_s  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s = int'(rr_ptr_r) + k;
      if (cand_s >= NUM_REQ) begin
        cand_s = cand_s - NUM_REQ;
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && bus.req_valid[IDX_W'(cand_s)]) begin
        found_s = 1'b1;
        pick_s  = IDX_W'(cand_s);
      end else begin
        found_s = found_s;
      end
    end
  end

  assign timeout_s = (tmo_cnt_r == 8'(TIMEOUT));
  assign term_s    = (bus.PENABLE & bus.PREADY) | bus.PSLVERR | timeout_s;

  // Transaction sequencer: arbitrate, latch command, watch completion, respond.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_r      <= ST_IDLE;
      rr_ptr_r     <= IDX_W'(NUM_REQ - 1);
      owner_r      <= {IDX_W{1'b0}};
      grant_r      <= {NUM_REQ{1'b0}};
      resp_valid_r <= {NUM_REQ{1'b0}};
      rw_r         <= 1'b0;
      addr_r       <= {ADDR_W{1'b0}};
      wdata_r      <= {DATA_W{1'b0}};
      rdata_r      <= {DATA_W{1'b0}};
      err_r        <= 1'b0;
      tmo_cnt_r    <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          resp_valid_r <= {NUM_REQ{1'b0}};
          tmo_cnt_r    <= 8'd0;
          if (found_s) begin
            grant_r <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_s;
            owner_r <= pick_s;
            rw_r    <= ~bus.req_write[pick_s];
            addr_r  <= bus.req_addr[int'(pick_s)*ADDR_W +: ADDR_W];
            wdata_r <= bus.req_write[pick_s] ?
                       bus.req_wdata[int'(pick_s)*DATA_W +: DATA_W] : {DATA_W{1'b0}};
            rdata_r <= {DATA_W{1'b0}};
            err_r   <= 1'b0;
            state_r <= ST_XFER;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_XFER: begin
          // PSLVERR outranks a same-cycle PREADY; a late PREADY outranks the watchdog.
          if (bus.PSLVERR) begin
            err_r        <= 1'b1;
            rdata_r      <= {DATA_W{1'b0}};
            resp_valid_r <= grant_r;
            state_r      <= ST_RESP;
          end else if (bus.PENABLE && bus.PREADY) begin
            err_r        <= 1'b0;
            rdata_r      <= rw_r ? bus.PRDATA : {DATA_W{1'b0}};
            resp_valid_r <= grant_r;
            state_r      <= ST_RESP;
          end else if (timeout_s) begin
            err_r        <= 1'b1;
            rdata_r      <= {DATA_W{1'b0}};
            resp_valid_r <= grant_r;
            state_r      <= ST_RESP;
          end else if (bus.PENABLE) begin
            tmo_cnt_r <= tmo_cnt_r + 8'd1;
          end else begin
            tmo_cnt_r <= 8'd0;
          end
        end
        ST_RESP: begin
          resp_valid_r <= {NUM_REQ{1'b0}};
          grant_r      <= {NUM_REQ{1'b0}};
          rr_ptr_r     <= owner_r;
          tmo_cnt_r    <= 8'd0;
          state_r      <= ST_IDLE;
        end
        default: begin
          resp_valid_r <= {NUM_REQ{1'b0}};
          grant_r      <= {NUM_REQ{1'b0}};
          tmo_cnt_r    <= 8'd0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_grant       = grant_r;
  assign bus.resp_valid      = resp_valid_r;
  assign bus.resp_rdata      = rdata_r;
  assign bus.resp_err        = err_r;
  assign bus.busy            = (state_r != ST_IDLE);
  assign bus.mst_transfer    = (state_r == ST_XFER) & ~term_s;
  assign bus.mst_read_write  = rw_r;
  assign bus.mst_write_paddr = addr_r;
  assign bus.mst_read_paddr  = addr_r;
  assign bus.mst_write_data  = wdata_r;
endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single APB master between NUM_REQ requesters.
- Accepts one read/write command per requester and latches the winning command.
- Drives the master's command inputs (transfer, READ_WRITE, read/write address, write data) and watches the APB completion handshake.
- Returns read data or an error status to the granted requester. A watchdog aborts transfers that stall on PREADY.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 9, address width; matches the master's 9-bit PADDR
- DATA_W, 8, data width
- TIMEOUT, 16, maximum consecutive PENABLE=1/PREADY=0 cycles before abort (1..255)

Ports:
- PCLK  in  1  clock; all logic on rising edge
- PRESET  in  1  asynchronous active-high reset
- req_valid  in  NUM_REQ  per-requester command valid; held until that requester's resp_valid
- req_write  in  NUM_REQ  per-requester direction; 1=write, 0=read
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  flattened write data
- req_grant  out  NUM_REQ  one-hot; set for the owner while a transaction is in flight
- resp_valid  out  NUM_REQ  one-cycle completion pulse to the owner
- resp_rdata  out  DATA_W  read data; valid with resp_valid on a read with resp_err=0
- resp_err  out  1  valid with resp_valid: PSLVERR or timeout
- busy  out  1  state != IDLE
- mst_transfer  out  1  to master transfer
- mst_read_write  out  1  to master READ_WRITE; 1=read
- mst_write_paddr  out  ADDR_W  to master apb_write_paddr
- mst_read_paddr  out  ADDR_W  to master apb_read_paddr
- mst_write_data  out  DATA_W  to master apb_write_data
- PENABLE  in  1  from master
- PREADY  in  1  APB slave ready
- PSLVERR  in  1  from master
- PRDATA  in  DATA_W  APB slave read data

Behaviour:
- Reset (async, PRESET=1):
  - state=IDLE.
  - All outputs, command registers and timeout counter are 0.
  - rr_ptr=NUM_REQ-1, so requester 0 has highest priority first.
  - Reset mid-transaction drops the transfer; no resp_valid is issued.
- State IDLE:
  - If any req_valid: choose the first set bit searching from rr_ptr+1 upward, modulo NUM_REQ.
  - Latch its write/addr/wdata into command registers and set req_grant.
  - Next state is XFER.
- Command register mapping:
  - mst_read_write = ~write.
  - Both mst_write_paddr and mst_read_paddr = latched addr.
  - mst_write_data = latched wdata for writes, 0 for reads.
  - All are registered and stable for the whole transaction.
- State XFER:
  - mst_transfer is combinational: 1 in XFER, except 0 in a terminating cycle.
  - Terminating cycle: (PENABLE & PREADY) or PSLVERR or timeout.
  - Completion (PENABLE & PREADY & !PSLVERR): capture PRDATA into resp_rdata (reads only; writes leave it 0); resp_err=0; next state is RESP.
  - PSLVERR=1 in any XFER cycle: abort; resp_err=1, resp_rdata=0; next state is RESP. PSLVERR takes priority over a simultaneous PREADY.
  - Timeout counter: increments on PENABLE=1 & PREADY=0; clears when PENABLE=0.
  - Counter reaches TIMEOUT: abort; resp_err=1; next state is RESP.
- State RESP (one cycle):
  - resp_valid[owner]=1 with resp_rdata/resp_err held.
  - rr_ptr=owner; req_grant cleared at the end of the cycle.
  - Next state is IDLE.
- Latency:
  - req_valid seen in IDLE at cycle 0 -> grant and mst_transfer at cycle 1.
  - resp_valid one cycle after the completion cycle.
  - At least one IDLE cycle between transactions.
- req_valid changes after grant are ignored; the command is already latched.
- A requester re-asserting req_valid in its resp_valid cycle is eligible in the next IDLE, but behind other pending requesters (round-robin).
- Simultaneous requests: exactly one grant; the rest wait.
- Starvation-free: each pending requester is served within NUM_REQ transactions.
- No retry on error. resp_rdata and resp_err are cleared at grant.

Test Plan:
- Single read: req_valid=0001, req_write[0]=0, addr0=0x012; slave PREADY=1 at the first PENABLE, PRDATA=0xA5 -> mst_read_write=1, mst_read_paddr=0x012; resp_valid=0001 with resp_rdata=0xA5, resp_err=0; one-cycle pulse.
- Single write: requester 2 writes 0xC3 to 0x1F0 -> mst_read_write=0, mst_write_paddr=0x1F0, mst_write_data=0xC3; resp_valid=0100, resp_err=0.
- Round-robin: req_valid=1111 held continuously after reset -> grant order 0,1,2,3,0; each grant one-hot.
- Wait states: PREADY low for 5 PENABLE cycles, then high -> mst_transfer stays 1; completion and resp_valid follow the PREADY cycle; resp_err=0.
- Timeout: PREADY never asserted, TIMEOUT=16 -> mst_transfer drops after 16 stalled PENABLE cycles; resp_err=1; busy returns to 0.
- Error and reset: PSLVERR=1 during XFER -> resp_err=1, resp_rdata=0. A separate case asserts PRESET mid-XFER -> all outputs 0 immediately, no resp_valid; next arbitration starts at requester 0.
